// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared mode encoding, digit width and blink-mask constants for the stopwatch counter.
package stopwatch_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BLINK_MIN = 4'b1100;
  localparam logic [3:0] BLINK_SEC = 4'b0011;
  localparam logic [3:0] BLINK_OFF = 4'b0000;
  typedef enum logic [1:0] {MODE_RUN, MODE_PAUSED, MODE_ADJUST} mode_t;
  function automatic logic [2*DIGIT_W-1:0] to_bcd(input int v);
    return {DIGIT_W'(v / 10), DIGIT_W'(v % 10)};
  endfunction
endpackage

// File: rtl/stopwatch_time_counter_field.sv
// bcd_mod60_field: two-digit BCD counter that rolls from max_val (or any illegal value) to 00 on inc.
module bcd_mod60_field
  import stopwatch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic [2*DIGIT_W-1:0]   max_val,
  output logic [DIGIT_W-1:0]     tens,
  output logic [DIGIT_W-1:0]     ones,
  output logic                   at_max
);
  logic illegal;
  always_comb begin
    at_max  = {tens, ones} == max_val;
    illegal = ones > DIGIT_W'(9) || tens > DIGIT_W'(5) || {tens, ones} > max_val;
  end
  always_ff @(posedge clk)
    if (rst) {tens, ones} <= '0;
    else if (inc)
      {tens, ones} <= (at_max || illegal) ? '0
                    : ones == DIGIT_W'(9) ? {tens + DIGIT_W'(1), DIGIT_W'(0)}
                    : {tens, ones + DIGIT_W'(1)};
endmodule

// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: BCD mm:ss counter with run/pause/adjust modes.
// STOPWATCH_SATURATE_EN: run-mode rollover at max holds the digits and pauses instead of wrapping.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int SEC_MAX       = 59,
  parameter int MIN_MAX       = 59,
  parameter bit RESET_RUNNING = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               tick_2hz,
  input  logic               pause_pulse,
  input  logic               adj,
  input  logic               sel,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic [3:0]         blink_mask,
  output logic               wrap
);
  mode_t mode;
  logic sec_at_max, min_at_max, run_tick, adj_tick, roll, sat_event, sat_q, sec_inc, min_inc;
  always_comb begin
    mode     = adj ? MODE_ADJUST : running ? MODE_RUN : MODE_PAUSED;
    run_tick = mode == MODE_RUN && tick_1hz;
    adj_tick = mode == MODE_ADJUST && tick_2hz;
    roll     = run_tick && sec_at_max && min_at_max;
    sec_inc  = (run_tick && !sat_event) || (adj_tick && sel);
    min_inc  = (run_tick && !sat_event && sec_at_max) || (adj_tick && !sel);
  end
`ifdef STOPWATCH_SATURATE_EN
  // sat_q marks "parked at max"; the first run tick after resuming rolls over silently.
  always_ff @(posedge clk)
    if (rst || adj) sat_q <= 1'b0;
    else if (sat_event) sat_q <= 1'b1;
    else if (run_tick) sat_q <= 1'b0;
  always_comb sat_event = roll && !sat_q;
`else
  always_comb sat_q = 1'b0;
  always_comb sat_event = 1'b0;
`endif
  bcd_mod60_field u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .max_val(to_bcd(SEC_MAX)),
    .tens(sec_tens), .ones(sec_ones), .at_max(sec_at_max)
  );
  bcd_mod60_field u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .max_val(to_bcd(MIN_MAX)),
    .tens(min_tens), .ones(min_ones), .at_max(min_at_max)
  );
  always_ff @(posedge clk)
    if (rst) begin
      running    <= RESET_RUNNING;
      wrap       <= 1'b0;
      blink_mask <= BLINK_OFF;
    end else begin
      running    <= sat_event ? 1'b0 : running ^ pause_pulse;
      wrap       <= roll && !sat_q;
      blink_mask <= adj ? (sel ? BLINK_SEC : BLINK_MIN) : BLINK_OFF;
    end
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// tb_stopwatch_time_counter: directed test plan plus random stimulus against an integer mm:ss reference model.
module tb_stopwatch_time_counter;
  localparam int SEC_MAX = 59, MIN_MAX = 59;
  localparam bit RESET_RUNNING = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0, tick_1hz = 1'b0, tick_2hz = 1'b0, pause_pulse = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blink_mask;
  logic running, wrap;
  int checks = 0, failures = 0;
  int m_s = 0, m_m = 0;
  bit m_run = 1'b0, m_wrap = 1'b0, m_sat = 1'b0;
  logic [3:0] m_blink = 4'd0;

  stopwatch_time_counter dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .pause_pulse(pause_pulse),
    .adj(adj), .sel(sel), .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .running(running), .blink_mask(blink_mask), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] shown();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic logic [15:0] model_time();
    return {4'(m_m / 10), 4'(m_m % 10), 4'(m_s / 10), 4'(m_s % 10)};
  endfunction

  // Reference: minutes/seconds as plain integers, updated from the mode rules.
  task automatic model_step();
    bit sat_evt = 1'b0;
    if (rst) begin
      m_s = 0; m_m = 0; m_run = RESET_RUNNING; m_wrap = 1'b0; m_blink = 4'd0; m_sat = 1'b0;
      return;
    end
    m_wrap = 1'b0;
    if (adj) begin
      m_sat = 1'b0;
      if (tick_2hz) begin
        if (sel) m_s = (m_s >= SEC_MAX) ? 0 : m_s + 1;
        else m_m = (m_m >= MIN_MAX) ? 0 : m_m + 1;
      end
    end else if (m_run && tick_1hz) begin
      if (m_s == SEC_MAX && m_m == MIN_MAX) begin
        if (SAT && !m_sat) begin
          sat_evt = 1'b1; m_sat = 1'b1; m_wrap = 1'b1;
        end else begin
          m_s = 0; m_m = 0; m_wrap = !m_sat; m_sat = 1'b0;
        end
      end else begin
        m_sat = 1'b0;
        if (m_s == SEC_MAX) begin m_s = 0; m_m++; end
        else m_s++;
      end
    end
    m_run = sat_evt ? 1'b0 : (pause_pulse ? !m_run : m_run);
    m_blink = adj ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
  endtask

  task automatic step(input bit r, input bit t1, input bit t2, input bit p, input bit a, input bit s);
    rst = r; tick_1hz = t1; tick_2hz = t2; pause_pulse = p; adj = a; sel = s;
    @(posedge clk);
    model_step();
    #1;
    chk("time", shown(), model_time());
    chk("running", running, m_run);
    chk("wrap", wrap, m_wrap);
    chk("blink", blink_mask, m_blink);
    rst = 0; tick_1hz = 0; tick_2hz = 0; pause_pulse = 0;
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    chk("reset_time", shown(), 16'h0000);
    chk("reset_run", running, RESET_RUNNING);
    // 1 and 3: run-mode counting and carries
    repeat (5) step(0, 1, 0, 0, 0, 0);
    chk("tp1_time", shown(), 16'h0005);
    chk("tp1_run", running, 1);
    repeat (4) step(0, 1, 0, 0, 0, 0);
    chk("tp3_09", shown(), 16'h0009);
    step(0, 1, 0, 0, 0, 0);
    chk("tp3_10", shown(), 16'h0010);
    repeat (49) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("tp3_100", shown(), 16'h0100);
    // 4: pause and tick together
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("tp4_time", shown(), 16'h0004);
    chk("tp4_run", running, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    chk("tp4_hold", shown(), 16'h0004);
    // 2: preload 59:59 and roll over
    repeat (55) step(0, 0, 1, 0, 1, 1);
    repeat (59) step(0, 0, 1, 0, 1, 0);
    chk("tp2_preload", shown(), 16'h5959);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("tp2_wrap", wrap, 1);
    chk("tp2_time", shown(), SAT ? 16'h5959 : 16'h0000);
    chk("tp2_run", running, SAT ? 0 : 1);
    step(0, 1, 0, 0, 0, 0);
    chk("tp2_wrap_once", wrap, 0);
    if (SAT) begin
      step(0, 0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("tp2_resume_time", shown(), 16'h0000);
      chk("tp2_resume_wrap", wrap, 0);
    end
    // 5: adjust stepping
    step(1, 0, 0, 0, 0, 0);
    repeat (58) step(0, 0, 1, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    chk("tp5_59", shown(), 16'h0059);
    step(0, 0, 1, 0, 1, 1);
    chk("tp5_00", shown(), 16'h0000);
    step(0, 0, 1, 0, 1, 1);
    chk("tp5_01", shown(), 16'h0001);
    chk("tp5_blink_sec", blink_mask, 4'b0011);
    repeat (2) step(0, 0, 1, 0, 1, 0);
    chk("tp5_min", shown(), 16'h0201);
    chk("tp5_blink_min", blink_mask, 4'b1100);
    step(0, 1, 0, 0, 1, 0);
    chk("tp5_t1_ignored", shown(), 16'h0201);
    // 6: reset beats tick and pause at 12:34
    repeat (10) step(0, 0, 1, 0, 1, 0);
    repeat (33) step(0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("tp6_preload", shown(), 16'h1234);
    step(1, 1, 0, 1, 0, 0);
    chk("tp6_time", shown(), 16'h0000);
    chk("tp6_run", running, RESET_RUNNING);
    chk("tp6_wrap", wrap, 0);
    // random traffic
    for (int i = 0; i < 6000; i++) begin
      bit a = adj, s = sel;
      if ($urandom_range(0, 39) == 0) a = !a;
      if ($urandom_range(0, 9) == 0) s = !s;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, a, s);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
- BCD minutes:seconds counter (00:00 to 59:59) that produces the four digit values consumed by the stopwatch display-mux stage.
- Counts on a 1 Hz tick enable when running.
- Supports pause toggle and manual adjust mode: the adj level plus the sel field select stepping at 2 Hz.
- Single clock domain; all timing comes from single-cycle tick enables, with no derived clocks.

Parameters:
- SEC_MAX, 59, highest seconds value before wrap (two-digit BCD, at most 59).
- MIN_MAX, 59, highest minutes value before wrap (two-digit BCD, at most 59).
- RESET_RUNNING, 1, run flag value after reset (1 = running, 0 = paused).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick_1hz  input  1  single-cycle count enable, 1 Hz rate.
- tick_2hz  input  1  single-cycle adjust-step enable, 2 Hz rate.
- pause_pulse  input  1  single-cycle debounced pause-button press; toggles run flag.
- adj  input  1  level; 1 = adjust mode.
- sel  input  1  level; adjust target: 0 = minutes, 1 = seconds.
- min_tens  output  4  minutes tens digit, 0..5.
- min_ones  output  4  minutes ones digit, 0..9.
- sec_tens  output  4  seconds tens digit, 0..5.
- sec_ones  output  4  seconds ones digit, 0..9.
- running  output  1  run flag.
- blink_mask  output  4  digits under adjustment, bit3 = min_tens .. bit0 = sec_ones; 0000 when adj=0.
- wrap  output  1  one-cycle pulse when a run-mode increment rolls over from max to 00:00.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All digits become 0 and wrap becomes 0.
  - running takes the value RESET_RUNNING.
  - rst overrides every other input in that cycle.
- Mode decode, evaluated every cycle:
  - RUN: adj=0, running=1.
  - PAUSED: adj=0, running=0.
  - ADJUST: adj=1, regardless of running.
- RUN mode:
  - On tick_1hz, sec_ones increments.
  - Ones 9 rolls to 0 and carries into tens.
  - Seconds value SEC_MAX rolls to 00 and carries into minutes.
  - Minutes value MIN_MAX rolls to 00 and asserts wrap for exactly 1 cycle.
  - Digit outputs update in the cycle after the tick edge; latency is 1 clock.
- PAUSED mode: digits hold; tick_1hz and tick_2hz are ignored.
- ADJUST mode:
  - tick_1hz is ignored.
  - On tick_2hz, the selected field increments by 1 with BCD rollover inside the field.
  - Seconds at SEC_MAX goes to 00 with no carry into minutes; minutes at MIN_MAX goes to 00.
  - wrap is never asserted in adjust mode.
  - blink_mask = 1100 when sel=0 and 0011 when sel=1.
- pause_pulse:
  - Toggles running in any mode, including ADJUST; the new value takes effect for the next tick.
  - pause_pulse and tick_1hz in the same cycle: the increment is decided from the pre-toggle running value.
  - Example: running with pause_pulse and tick_1hz together gives count+1 and running=0.
- adj or sel changing mid-count: takes effect on the next tick. There is no pending or partial-increment state.
- tick_1hz and tick_2hz in the same cycle: only the tick relevant to the current mode acts.
- Illegal digit values are unreachable. If one occurs, the next increment of that field forces the field to 00.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: STOPWATCH_SATURATE_EN.
- Defined:
  - In RUN mode, at MIN_MAX:SEC_MAX a tick_1hz does not wrap; digits hold at max.
  - running clears to 0 and wrap pulses once.
  - Further ticks have no effect until pause_pulse, adjust, or rst.
  - Resuming from max via pause_pulse: the next tick wraps to 00:00 with no wrap pulse.
- Undefined: the wrap-around behaviour described above.
- Adjust mode is identical in both builds.

Decomposition:
- Shared package stopwatch_pkg:
  - Mode encoding (MODE_RUN, MODE_PAUSED, MODE_ADJUST).
  - Digit width constant DIGIT_W = 4.
  - Blink-mask constants BLINK_MIN = 4'b1100, BLINK_SEC = 4'b0011.
- One sub-module, bcd_mod60_field:
  - Two-digit BCD counter with inputs inc and max_val.
  - Outputs: tens, ones, and a combinational at_max flag.
  - Instantiated twice, once for seconds and once for minutes. The top computes carry chaining and mode gating.

Test Plan:
1. rst, then 5 tick_1hz in RUN -> digits 00:05, running=1, wrap never asserted.
2. Preload 59:59 via adjust, adj=0, one tick_1hz -> 00:00 on the next cycle, wrap high for exactly 1 cycle. With STOPWATCH_SATURATE_EN the digits stay 59:59, running=0, wrap pulses once.
3. Count to 00:09, one tick_1hz -> 00:10; at 00:59, one tick -> 01:00.
4. Running with pause_pulse and tick_1hz in the same cycle at 00:03 -> 00:04 and running=0. 3 further tick_1hz -> still 00:04.
5. adj=1, sel=1, seconds at 58, 3 tick_2hz -> seconds 59, 00, 01 with minutes unchanged and blink_mask=0011. sel=0, 2 tick_2hz -> minutes +2, blink_mask=1100. tick_1hz during adjust has no effect.
6. rst asserted in the same cycle as tick_1hz and pause_pulse at 12:34 -> 00:00, running=RESET_RUNNING, wrap=0.
